// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: line levels, frame length, arbiter state encoding and frame builder.
// The TAG state and TAG_BASE exist only when ARB_TAG_EN is defined.
package serial_tx_pkg;

  localparam logic MARKING   = 1'b1;
  localparam logic SPACING   = 1'b0;
  localparam int   FRAME_LEN = 10;

`ifdef ARB_TAG_EN
  localparam logic [7:0] TAG_BASE = 8'h80;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
`ifdef ARB_TAG_EN
    ,TAG  = 2'd3
`endif
  } state_t;

  // Frame is transmitted from bit 0: start bit, data LSB first, stop bit.
  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] data);
    return {MARKING, data, SPACING};
  endfunction

endpackage

// File: rtl/tx_frame_shift.sv
// tx_frame_shift: 10-bit frame serializer with bit-time divider and bit counter.
// A load while the final stop bit completes chains the next frame with no idle bits.
module tx_frame_shift
  import serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 i_load,
  input  logic [FRAME_LEN-1:0] i_frame,
  output logic                 o_txd,
  output logic                 o_done
);

  localparam int               DIV_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_CYCLES - 1);
  localparam logic [3:0]       CNT_FULL   = 4'(FRAME_LEN);

  logic [FRAME_LEN-1:0] r_buf;
  logic [3:0]           r_cnt;     // bit currently on the line: 10 = start ... 1 = stop
  logic [DIV_W-1:0]     r_div;
  logic                 r_active;
  logic                 r_started;
  logic                 r_txd;

  logic w_bit_end;
  logic w_frame_end;
  logic w_emit;

  assign w_bit_end   = r_started && (r_div == '0);
  assign w_frame_end = r_active && w_bit_end && (r_cnt == 4'd1);
  assign w_emit      = r_active && (!r_started || (w_bit_end && (r_cnt != 4'd1)));

  // NOTE: every register here uses <= so each one samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      // NOTE: the frame buffer is ordinary flops, so it is cleared with the rest of the state.
      r_buf     <= '1;
      r_cnt     <= '0;
      r_div     <= '0;
      r_active  <= 1'b0;
      r_started <= 1'b0;
      r_txd     <= MARKING;
    end else if (i_load && r_active) begin
      // Chained frame: its start bit takes the edge the stop bit would have ended on.
      r_txd     <= i_frame[0];
      r_buf     <= {MARKING, i_frame[FRAME_LEN-1:1]};
      r_cnt     <= CNT_FULL;
      r_div     <= DIV_RELOAD;
      r_started <= 1'b1;
    end else if (i_load) begin
      r_buf     <= i_frame;
      r_cnt     <= CNT_FULL;
      r_div     <= '0;
      r_started <= 1'b0;
      r_active  <= 1'b1;
    end else if (w_frame_end) begin
      r_active  <= 1'b0;
      r_started <= 1'b0;
    end else if (w_emit) begin
      r_txd     <= r_buf[0];
      r_buf     <= {MARKING, r_buf[FRAME_LEN-1:1]};
      if (r_started) r_cnt <= r_cnt - 4'd1;
      r_started <= 1'b1;
      r_div     <= DIV_RELOAD;
    end else if (r_active) begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  assign o_txd  = r_txd;
  assign o_done = w_frame_end;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter framing bytes from two dav_/rfd producers onto txd.
// Define ARB_TAG_EN to precede each data frame with a tag frame 8'h80|requester.
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav0_,
  input  logic [7:0] byte0,
  output logic       rfd0,
  input  logic       dav1_,
  input  logic [7:0] byte1,
  output logic       rfd1,
  output logic       txd,
  output logic       busy
);

  state_t r_state;
  logic   r_gnt;
  logic   r_last;
  logic   r_rfd0;
  logic   r_rfd1;
  logic   r_busy;
`ifdef ARB_TAG_EN
  logic [7:0] r_data;
`endif

  logic                 w_req0;
  logic                 w_req1;
  logic                 w_grant;
  logic                 w_pick;
  logic                 w_dav_gnt;
  logic                 w_load;
  logic                 w_done;
  logic                 w_txd;
  logic [7:0]           w_byte;
  logic [FRAME_LEN-1:0] w_frame;

  assign w_req0    = ~dav0_;
  assign w_req1    = ~dav1_;
  assign w_grant   = w_req0 | w_req1;
  // With both requesting, the one not served last wins.
  assign w_pick    = (w_req0 && w_req1) ? ~r_last : w_req1;
  assign w_byte    = w_pick ? byte1 : byte0;
  assign w_dav_gnt = r_gnt ? dav1_ : dav0_;

  // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
  always_comb begin
    w_load  = 1'b0;
    w_frame = make_frame(w_byte);
    case (r_state)
      IDLE: begin
        w_load = w_grant;
`ifdef ARB_TAG_EN
        w_frame = make_frame(TAG_BASE | {7'd0, w_pick});
`endif
      end
`ifdef ARB_TAG_EN
      TAG: begin
        w_load  = w_done;
        w_frame = make_frame(r_data);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_rfd0  <= 1'b1;
      r_rfd1  <= 1'b1;
      r_busy  <= 1'b0;
`ifdef ARB_TAG_EN
      r_data  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_gnt  <= w_pick;
            r_last <= w_pick;
            if (w_pick) r_rfd1 <= 1'b0;
            else        r_rfd0 <= 1'b0;
            r_busy <= 1'b1;
`ifdef ARB_TAG_EN
            r_data  <= w_byte;
            r_state <= TAG;
`else
            r_state <= SHIFT;
`endif
          end
        end
`ifdef ARB_TAG_EN
        TAG: begin
          if (w_done) r_state <= SHIFT;
        end
`endif
        SHIFT: begin
          if (w_done) r_state <= WAIT;
        end
        WAIT: begin
          // rfd stays low until the producer has visibly withdrawn its request.
          if (w_dav_gnt) begin
            if (r_gnt) r_rfd1 <= 1'b1;
            else       r_rfd0 <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  tx_frame_shift #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_shift (
    .clock  (clock),
    .reset_ (reset_),
    .i_load (w_load),
    .i_frame(w_frame),
    .o_txd  (w_txd),
    .o_done (w_done)
  );

  assign rfd0 = r_rfd0;
  assign rfd1 = r_rfd1;
  assign txd  = w_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance at BIT_CYCLES=1, one at BIT_CYCLES=3.
// Expectations follow ARB_TAG_EN when the bundle is built with it.
module tb_serial_tx_arbiter;
  import serial_tx_pkg::*;

`ifdef ARB_TAG_EN
  localparam int FRAME_CLKS = 20;
`else
  localparam int FRAME_CLKS = 10;
`endif

  logic       clock;
  logic       reset_;
  logic       dav0_, dav1_, rfd0, rfd1, txd, busy;
  logic [7:0] byte0, byte1;
  logic       c_dav0_, c_dav1_, c_rfd0, c_rfd1, c_txd, c_busy;
  logic [7:0] c_byte0, c_byte1;

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  serial_tx_arbiter #(.BIT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_(reset_),
    .dav0_(dav0_), .byte0(byte0), .rfd0(rfd0),
    .dav1_(dav1_), .byte1(byte1), .rfd1(rfd1),
    .txd(txd), .busy(busy)
  );

  serial_tx_arbiter #(.BIT_CYCLES(3)) u_dut3 (
    .clock(clock), .reset_(reset_),
    .dav0_(c_dav0_), .byte0(c_byte0), .rfd0(c_rfd0),
    .dav1_(c_dav1_), .byte1(c_byte1), .rfd1(c_rfd1),
    .txd(c_txd), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rfd(input logic which, input logic lvl, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if ((which ? rfd1 : rfd0) === lvl) ok = 1'b1;
    end
  endtask

  // Captures the next data frame on txd (skipping the tag frame when present).
  task automatic capture1(output logic [9:0] f);
    logic found;
    found = 1'b0;
    f     = 'x;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clock);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
`ifdef ARB_TAG_EN
      repeat (10) @(negedge clock);
`endif
      f[0] = txd;
      for (int i = 1; i < 10; i++) begin
        @(negedge clock);
        f[i] = txd;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  got, exp10;
    logic [19:0] got20, exp20;
    logic        ok, found, r;
    int          cnt;

    reset_ = 1'b0;
    dav0_ = 1'b1; dav1_ = 1'b1; byte0 = '0; byte1 = '0;
    c_dav0_ = 1'b1; c_dav1_ = 1'b1; c_byte0 = '0; c_byte1 = '0;
    repeat (3) @(negedge clock);
    check("rst_txd", txd, 1);
    check("rst_rfd0", rfd0, 1);
    check("rst_rfd1", rfd1, 1);
    check("rst_busy", busy, 0);
    check("rst_c_txd", c_txd, 1);
    reset_ = 1'b1;

    // Requester 0 sends 0x5A.
    byte0 = 8'h5A; dav0_ = 1'b0;
    @(negedge clock);
    check("t2_gnt_rfd0", rfd0, 0);
    check("t2_gnt_busy", busy, 1);
    check("t2_gnt_txd", txd, 1);
    dav0_ = 1'b1;
`ifdef ARB_TAG_EN
    repeat (10) @(negedge clock);
`endif
    exp10 = 10'b1010110100;
    got   = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      got[i] = txd;
    end
    check("t2_bits", got, exp10);
    check("t2_rfd0_mid", rfd0, 0);
    @(negedge clock);
    check("t2_wait_rfd0", rfd0, 0);
    check("t2_wait_busy", busy, 1);
    @(negedge clock);
    check("t2_rel_rfd0", rfd0, 1);
    check("t2_rel_busy", busy, 0);

    // Requester 0 holds dav0_ low after its frame while requester 1 waits.
    byte0 = 8'h33; dav0_ = 1'b0;
    @(negedge clock);
    check("t4_gnt_rfd0", rfd0, 0);
    byte1 = 8'h44; dav1_ = 1'b0;
    repeat (FRAME_CLKS) @(negedge clock);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rfd0 === 1'b0 && busy === 1'b1 && txd === 1'b1 && rfd1 === 1'b1) cnt++;
    end
    check("t4_hold_clocks", cnt, 5);
    dav0_ = 1'b1;
    @(negedge clock);
    check("t4_rel_rfd0", rfd0, 1);
    check("t4_rel_busy", busy, 0);
    check("t4_rel_rfd1", rfd1, 1);
    @(negedge clock);
    check("t4_gnt1_rfd1", rfd1, 0);
    check("t4_gnt1_busy", busy, 1);
    dav1_ = 1'b1;
    capture1(got);
    check("t4_frame1", got, {1'b1, 8'h44, 1'b0});
    repeat (4) @(negedge clock);
    check("t4_end_busy", busy, 0);

    // Both requesters keep offering bytes; grants alternate starting with 0.
    byte0 = 8'h11; byte1 = 8'h22; dav0_ = 1'b0; dav1_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = i[0];
      wait_rfd(r, 1'b0, ok);
      check($sformatf("t3_gnt%0d", i), ok, 1);
      check($sformatf("t3_other%0d", i), r ? rfd0 : rfd1, 1);
      if (r) dav1_ = 1'b1;
      else   dav0_ = 1'b1;
      capture1(got);
      check($sformatf("t3_frame%0d", i), got, r ? {1'b1, 8'h22, 1'b0} : {1'b1, 8'h11, 1'b0});
      wait_rfd(r, 1'b1, ok);
      check($sformatf("t3_rel%0d", i), ok, 1);
      if (i < 3) begin
        if (r) dav1_ = 1'b0;
        else   dav0_ = 1'b0;
      end
    end
    dav0_ = 1'b1; dav1_ = 1'b1;
    @(negedge clock);
    check("t3_end_busy", busy, 0);

    // Requester 1 sends 0x0F: tag frame 0x81 first when tagging is built in.
    byte1 = 8'h0F; dav1_ = 1'b0;
    wait_rfd(1'b1, 1'b0, ok);
    check("t6_gnt", ok, 1);
    dav1_ = 1'b1;
    found = 1'b0;
    got20 = 'x;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      got20[0] = txd;
      for (int i = 1; i < 20; i++) begin
        @(negedge clock);
        got20[i] = txd;
      end
    end
`ifdef ARB_TAG_EN
    exp20 = {10'b1000011110, 10'b1100000010};
`else
    exp20 = {10'b1111111111, 10'b1000011110};
`endif
    check("t6_bits20", got20, exp20);
    repeat (4) @(negedge clock);
    check("t6_end_busy", busy, 0);

    // BIT_CYCLES=3, byte 0xFF.
    c_byte0 = 8'hFF; c_dav0_ = 1'b0;
    @(negedge clock);
    check("t5_gnt_rfd0", c_rfd0, 0);
    check("t5_gnt_busy", c_busy, 1);
    check("t5_gnt_txd", c_txd, 1);
    c_dav0_ = 1'b1;
`ifdef ARB_TAG_EN
    repeat (30) @(negedge clock);
`endif
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (c_txd === 1'b0) cnt++;
    end
    check("t5_start_clocks", cnt, 3);
    cnt = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      if (c_txd === 1'b1) cnt++;
    end
    check("t5_high_clocks", cnt, 27);
    check("t5_still_shift", 32'(u_dut3.r_state), 32'(SHIFT));
    @(negedge clock);
    check("t5_wait_state", 32'(u_dut3.r_state), 32'(WAIT));
    check("t5_wait_txd", c_txd, 1);
    @(negedge clock);
    check("t5_rel_rfd0", c_rfd0, 1);
    check("t5_rel_busy", c_busy, 0);

    // Asynchronous reset in the middle of a frame, request left pending.
    byte0 = 8'hA5; dav0_ = 1'b0;
    @(negedge clock);
    check("t1_gnt_rfd0", rfd0, 0);
    repeat (5) @(negedge clock);
    check("t1_bit4_txd", txd, 0);
    #2 reset_ = 1'b0;
    #1;
    check("t1_async_txd", txd, 1);
    check("t1_async_rfd0", rfd0, 1);
    check("t1_async_rfd1", rfd1, 1);
    check("t1_async_busy", busy, 0);
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    check("t1_regrant_rfd0", rfd0, 0);
    check("t1_regrant_busy", busy, 1);
    dav0_ = 1'b1;
    capture1(got);
    check("t1_frame", got, {1'b1, 8'hA5, 1'b0});
    repeat (4) @(negedge clock);
    check("t1_end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
